// File: rtl/msx_bus_request_if.sv
// msx_bus_request_if: request/ready handshake between the MSX bus front end and internal targets
interface msx_bus_request_if;
  logic        bus_valid;
  logic        bus_ioreq;
  logic        bus_write;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic        bus_ready;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  modport master (
    output bus_valid, bus_ioreq, bus_write, bus_address, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );
  modport slave (
    input  bus_valid, bus_ioreq, bus_write, bus_address, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/msx_bus_request.sv
// msx_bus_request: turns each MSX slot-memory or I/O strobe into one request/ready transaction
// Strobes are synchronised, the address is allowed to settle, and read data drives the MSX bus.
module msx_bus_request #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_SETTLE = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] i_address,
  input  logic        i_n_sltsl,
  input  logic        i_n_merq,
  input  logic        i_n_iorq,
  input  logic        i_n_rd,
  input  logic        i_n_wr,
  input  logic [7:0]  i_d_in,
  output logic [7:0]  o_d_out,
  output logic        o_d_oe,
  msx_bus_request_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, REQ, HOLD} state_t;
  localparam logic [7:0] SETTLE_LOAD = 8'(ADDR_SETTLE - 1);
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);
  logic [4:0] r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_warm;
  state_t r_state, w_state;
  logic [7:0] r_cnt, w_cnt, r_wdata, w_wdata, r_dout, w_dout;
  logic [15:0] r_addr, w_addr;
  logic r_armed, w_armed, r_ioreq, w_ioreq, r_write, w_write, r_valid, w_valid, r_doe, w_doe;
  logic w_s_sltsl, w_s_merq, w_s_iorq, w_s_rd, w_s_wr, w_io, w_start, w_strb;
  assign {w_s_sltsl, w_s_merq, w_s_iorq, w_s_rd, w_s_wr} = ~r_sync[SYNC_STAGES-1];
  assign w_io = w_s_iorq & ~w_s_merq;
  assign w_start = r_armed & (w_s_rd ^ w_s_wr) & ((w_s_merq & w_s_sltsl) | w_io);
  assign w_strb = r_write ? w_s_wr : w_s_rd;
  assign bus.bus_valid = r_valid;
  assign bus.bus_ioreq = r_ioreq;
  assign bus.bus_write = r_write;
  assign bus.bus_address = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign o_d_out = r_dout;
  assign o_d_oe = r_doe;
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '1;
      r_warm <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_armed <= 1'b0;
      r_ioreq <= 1'b0;
      r_write <= 1'b0;
      r_valid <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_dout <= '0;
      r_doe <= 1'b0;
    end else begin
      r_sync[0] <= {i_n_sltsl, i_n_merq, i_n_iorq, i_n_rd, i_n_wr};
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_warm <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_armed <= w_armed;
      r_ioreq <= w_ioreq;
      r_write <= w_write;
      r_valid <= w_valid;
      r_addr <= w_addr;
      r_wdata <= w_wdata;
      r_dout <= w_dout;
      r_doe <= w_doe;
    end
  end
  // Arming waits for the sync chain to hold real pin samples, so a strobe held through reset stays ignored
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_armed = r_armed | (r_warm[SYNC_STAGES-1] & ~w_s_rd & ~w_s_wr);
    w_ioreq = r_ioreq;
    w_write = r_write;
    w_valid = r_valid;
    w_addr = r_addr;
    w_wdata = r_wdata;
    w_dout = r_dout;
    w_doe = r_doe;
    case (r_state)
      IDLE: if (w_start) begin
        w_state = SETTLE;
        w_cnt = SETTLE_LOAD;
        w_ioreq = w_io;
        w_write = w_s_wr;
        w_armed = 1'b0;
      end
      SETTLE: if (!w_strb) w_state = IDLE;
      else if (r_cnt == 8'd0) begin
        w_addr = i_address;
        w_wdata = r_write ? i_d_in : r_wdata;
        w_valid = 1'b1;
        w_cnt = TMO_LOAD;
        w_state = REQ;
      end else w_cnt = r_cnt - 8'd1;
      REQ: if (bus.bus_ready) begin
        w_valid = 1'b0;
        w_state = HOLD;
        w_doe = ~r_write & bus.bus_rdata_en;
        w_dout = w_doe ? bus.bus_rdata : r_dout;
      end else if (r_cnt == 8'd0) begin
        w_valid = 1'b0;
        w_state = HOLD;
      end else w_cnt = r_cnt - 8'd1;
      HOLD: if (!w_strb) begin
        w_doe = 1'b0;
        w_dout = '0;
        w_state = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_msx_bus_request.sv
// tb_msx_bus_request: directed and random MSX accesses checked against a cycle-timing reference model
module tb_msx_bus_request;
  localparam int SYNC = 2, SETTLE = 8, TMO = 255;
  localparam int FIRST = SYNC + SETTLE + 1;
  logic clk = 1'b0, n_reset = 1'b0;
  logic [15:0] address = '0;
  logic n_sltsl = 1'b1, n_merq = 1'b1, n_iorq = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
  logic [7:0] d_in = '0, d_out;
  logic d_oe;
  int checks = 0, errors = 0;
  msx_bus_request_if bif();
  msx_bus_request #(.SYNC_STAGES(SYNC), .ADDR_SETTLE(SETTLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_reset(n_reset), .i_address(address), .i_n_sltsl(n_sltsl), .i_n_merq(n_merq),
    .i_n_iorq(n_iorq), .i_n_rd(n_rd), .i_n_wr(n_wr), .i_d_in(d_in), .o_d_out(d_out), .o_d_oe(d_oe),
    .bus(bif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Pins are driven at a negedge; sample k is the k-th negedge after that.
  // Model: request appears at sample SYNC+SETTLE+1, lasts rdy samples (or TIMEOUT),
  // d_oe follows ready by one sample and lasts until the synced strobe release is seen.
  task automatic access(input string tag, input bit sl, mq, iq, rdl, wrl,
                        input logic [15:0] a, a2, input int chg, input logic [7:0] wd,
                        input int hold, rdy, input logic [7:0] rdat, input bit en);
    bit req, io, prev, vexp, oexp;
    int nreq, vend, oend, last;
    logic [15:0] ea;
    req = ((mq && sl) || (iq && !mq)) && (rdl ^ wrl) && hold >= SYNC + SETTLE - 1;
    io = iq && !mq;
    vend = FIRST + (rdy > 0 ? rdy : TMO);
    oend = hold + 2 > vend ? hold + 2 : vend;
    ea = (chg > 0 && chg < FIRST) ? a2 : a;
    last = (hold > vend ? hold : vend) + 5;
    address = a; d_in = wd; bif.bus_rdata = rdat; bif.bus_rdata_en = en;
    n_sltsl = !sl; n_merq = !mq; n_iorq = !iq; n_rd = !rdl; n_wr = !wrl;
    nreq = 0; prev = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      vexp = req && k >= FIRST && k < vend;
      oexp = req && rdl && rdy > 0 && en && k >= vend && k <= oend;
      chk({tag, ".valid"}, bif.bus_valid, vexp);
      chk({tag, ".d_oe"}, d_oe, oexp);
      if (vexp) begin
        chk({tag, ".addr"}, bif.bus_address, ea);
        chk({tag, ".ioreq"}, bif.bus_ioreq, io);
        chk({tag, ".write"}, bif.bus_write, wrl);
        if (wrl) chk({tag, ".wdata"}, bif.bus_wdata, wd);
      end
      if (oexp) chk({tag, ".d_out"}, d_out, rdat);
      if (bif.bus_valid && !prev) nreq++;
      prev = bif.bus_valid;
      bif.bus_ready = rdy > 0 && k == vend - 1;
      if (k == hold) {n_sltsl, n_merq, n_iorq, n_rd, n_wr} = '1;
      if (k == chg) address = a2;
    end
    chk({tag, ".nreq"}, nreq, req);
    chk({tag, ".d_out_end"}, d_out, 0);
  endtask
  initial begin
    bif.bus_ready = 1'b0; bif.bus_rdata = '0; bif.bus_rdata_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.valid", bif.bus_valid, 0);
    chk("reset.addr", bif.bus_address, 0);
    chk("reset.wdata", bif.bus_wdata, 0);
    chk("reset.d_oe", d_oe, 0);
    chk("reset.d_out", d_out, 0);
    n_reset = 1'b1;
    repeat (6) @(negedge clk);
    access("mem_rd", 1, 1, 0, 1, 0, 16'h4010, 16'h4010, 0, 8'h00, 20, 3, 8'hA5, 1);
    access("io_wr", 0, 0, 1, 0, 1, 16'h0098, 16'h0098, 0, 8'h3C, 20, 2, 8'h77, 1);
    access("abort", 1, 1, 0, 1, 0, 16'h4000, 16'h4000, 0, 8'h00, 6, 1, 8'h11, 1);
    access("abort.next", 1, 1, 0, 1, 0, 16'h4001, 16'h4001, 0, 8'h00, 20, 1, 8'h5A, 1);
    access("hold8", 1, 1, 0, 1, 0, 16'h8000, 16'h8000, 0, 8'h00, 8, 1, 8'h22, 1);
    access("hold9", 1, 1, 0, 1, 0, 16'h8001, 16'h8001, 0, 8'h00, 9, 1, 8'h33, 1);
    access("no_resp", 1, 1, 0, 1, 0, 16'hC000, 16'hC000, 0, 8'h00, 20, 2, 8'h44, 0);
    access("tmo", 1, 1, 0, 1, 0, 16'h6000, 16'h6000, 0, 8'h00, 20, 0, 8'h55, 1);
    address = 16'h2345; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
    repeat (FIRST + 2) @(negedge clk);
    chk("rst.pre_valid", bif.bus_valid, 1);
    n_reset = 1'b0;
    @(negedge clk);
    chk("rst.valid", bif.bus_valid, 0);
    chk("rst.addr", bif.bus_address, 0);
    chk("rst.d_oe", d_oe, 0);
    n_reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rst.no_req", bif.bus_valid, 0);
    end
    {n_sltsl, n_merq, n_iorq, n_rd, n_wr} = '1;
    repeat (5) @(negedge clk);
    access("rst.after", 1, 1, 0, 1, 0, 16'h2346, 16'h2346, 0, 8'h00, 20, 2, 8'h99, 1);
    access("rd_wr", 1, 1, 0, 1, 1, 16'h1000, 16'h1000, 0, 8'h12, 20, 2, 8'h66, 1);
    access("sltsl_hi", 0, 1, 0, 1, 0, 16'h1001, 16'h1001, 0, 8'h00, 20, 2, 8'h66, 1);
    access("addr_chg", 1, 1, 0, 1, 0, 16'h1234, 16'h5678, 5, 8'h00, 20, 2, 8'hC3, 1);
    for (int i = 0; i < 12; i++) begin
      int kind;
      bit sl, mq, iq, wr;
      kind = $urandom_range(0, 3);
      sl = kind == 0 ? 1'b1 : kind == 1 ? 1'b0 : 1'($urandom_range(0, 1));
      mq = kind == 0 ? 1'b1 : kind == 1 ? 1'b0 : 1'($urandom_range(0, 1));
      iq = kind == 0 ? 1'b0 : kind == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      access($sformatf("rnd%0d", i), sl, mq, iq, !wr, wr, 16'($urandom), 16'h0, 0, 8'($urandom),
             $urandom_range(5, 30), $urandom_range(1, 6), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
